// File: rtl/io_intr_ctrl.sv
// Interrupt controller: edge-latched pending, enable mask, single intr held until an EOI write to ICUR.
// Latency: dev_req rise -> intr two edges later. No backpressure; bus reads are combinational.
// INTR_ROUNDROBIN_EN selects round-robin arbitration instead of fixed lowest-index priority.
module io_intr_ctrl #(
   parameter int          NDEV  = 4,
   parameter logic [31:0] ISTAT = 32'hF0000800,
   parameter logic [31:0] IMASK = 32'hF0000804,
   parameter logic [31:0] ICUR  = 32'hF0000808
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [31:0]     abus,
   input  logic [31:0]     dbus,
   input  logic            wren,
   input  logic [NDEV-1:0] dev_req,
   output logic [31:0]     dbusout,
   output logic            intr,
   output logic [7:0]      intr_id
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARB   = 2'd1,
      SERVE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [NDEV-1:0] pending_q, pending_d;
   logic [NDEV-1:0] mask_q, mask_d;
   logic [NDEV-1:0] req_q, req_d;
   logic [7:0]      cur_id_q, cur_id_d;
   logic            intr_q, intr_d;
`ifdef INTR_ROUNDROBIN_EN
   logic [7:0]      rr_ptr_q, rr_ptr_d;
`endif

   logic [NDEV-1:0] cand;
   logic [NDEV-1:0] clr;
   logic [7:0]      win_id;
   logic            win_vld;
   logic            ack;
   logic            unused_dbus;

   assign unused_dbus = ^dbus[31:8];
   assign cand        = pending_q & mask_q;
   // An EOI only counts in SERVE and only for the id currently being served.
   assign ack         = (state_q == SERVE) && wren && (abus == ICUR) && (dbus[7:0] == cur_id_q);

   always_comb begin
      clr = '0;
      for (int j = 0; j < NDEV; j++) begin
         clr[j] = ack && (cur_id_q == 8'(j));
      end
   end

   always_comb begin
`ifdef INTR_ROUNDROBIN_EN
      int best;
      int dist;
      best    = NDEV;
      dist    = 0;
      win_id  = '0;
      // Winner is the candidate at the smallest upward distance from rr_ptr.
      for (int j = 0; j < NDEV; j++) begin
         if (cand[j]) begin
            dist = (j >= int'(rr_ptr_q)) ? (j - int'(rr_ptr_q)) : (j + NDEV - int'(rr_ptr_q));
            if (dist < best) begin
               best   = dist;
               win_id = 8'(j);
            end
         end
      end
`else
      win_id = '0;
      for (int j = NDEV - 1; j >= 0; j--) begin
         if (cand[j]) begin
            win_id = 8'(j);
         end
      end
`endif
      win_vld = |cand;
   end

   always_comb begin
      req_d     = dev_req;
      // Set wins over clear when a new edge lands on the bit being acknowledged.
      pending_d = (pending_q & ~clr) | (dev_req & ~req_q);
      mask_d    = mask_q;
      state_d   = state_q;
      cur_id_d  = cur_id_q;
`ifdef INTR_ROUNDROBIN_EN
      rr_ptr_d  = rr_ptr_q;
`endif
      if (wren && (abus == IMASK)) begin
         mask_d = dbus[NDEV-1:0];
      end
      case (state_q)
         IDLE: begin
            if (|cand) begin
               state_d = ARB;
            end
         end
         ARB: begin
            if (win_vld) begin
               cur_id_d = win_id;
               state_d  = SERVE;
            end else begin
               state_d  = IDLE;
            end
         end
         SERVE: begin
            if (ack) begin
               state_d = IDLE;
`ifdef INTR_ROUNDROBIN_EN
               rr_ptr_d = ((int'(cur_id_q) + 1) >= NDEV) ? 8'd0 : (cur_id_q + 8'd1);
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      intr_d = (state_d == SERVE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         mask_q    <= '0;
         req_q     <= '0;
         cur_id_q  <= '0;
         intr_q    <= 1'b0;
`ifdef INTR_ROUNDROBIN_EN
         rr_ptr_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         req_q     <= req_d;
         cur_id_q  <= cur_id_d;
         intr_q    <= intr_d;
`ifdef INTR_ROUNDROBIN_EN
         rr_ptr_q  <= rr_ptr_d;
`endif
      end
   end

   always_comb begin
      dbusout = '0;
      if (!wren) begin
         if (abus == ISTAT) begin
            dbusout[NDEV-1:0] = pending_q;
         end else if (abus == IMASK) begin
            dbusout[NDEV-1:0] = mask_q;
         end else if (abus == ICUR) begin
            dbusout = {(state_q == SERVE), 23'b0, cur_id_q};
         end
      end
   end

   assign intr    = intr_q;
   assign intr_id = cur_id_q;

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Randomized and directed bench for io_intr_ctrl against a cycle-level reference model.
module tb_io_intr_ctrl;

   localparam int          NDEV  = 4;
   localparam logic [31:0] ISTAT = 32'hF0000800;
   localparam logic [31:0] IMASK = 32'hF0000804;
   localparam logic [31:0] ICUR  = 32'hF0000808;
   localparam logic [31:0] OTHER = 32'h00001000;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [31:0]     abus;
   logic [31:0]     dbus;
   logic            wren;
   logic [NDEV-1:0] dev_req;
   logic [31:0]     dbusout;
   logic            intr;
   logic [7:0]      intr_id;

   io_intr_ctrl #(.NDEV(NDEV), .ISTAT(ISTAT), .IMASK(IMASK), .ICUR(ICUR)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .abus    (abus),
      .dbus    (dbus),
      .wren    (wren),
      .dev_req (dev_req),
      .dbusout (dbusout),
      .intr    (intr),
      .intr_id (intr_id)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: phase 0 waiting, 1 choosing, 2 serving.
   bit [NDEV-1:0] m_pend, m_msk, m_prev;
   int            m_phase, m_cur, m_rr;

   logic [31:0] last_rd;
   logic        last_intr;
   logic [7:0]  last_id;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic int pick(input bit [NDEV-1:0] c, input int rr);
      for (int k = 0; k < NDEV; k++) begin
         int i;
         i = (rr + k) % NDEV;
         if (c[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [31:0] model_rd(input logic w, input logic [31:0] a);
      if (w) return 32'h0;
      if (a == ISTAT) return 32'(m_pend);
      if (a == IMASK) return 32'(m_msk);
      if (a == ICUR)  return {(m_phase == 2), 23'b0, 8'(m_cur)};
      return 32'h0;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_msk = '0; m_prev = '0;
      m_phase = 0; m_cur = 0; m_rr = 0;
   endtask

   task automatic model_step(input logic rst, input logic [NDEV-1:0] r, input logic w,
                             input logic [31:0] a, input logic [31:0] d);
      bit [NDEV-1:0] cand, clrv, rise;
      bit            ackv;
      int            nphase, win;
      if (!rst) begin
         model_reset();
         return;
      end
      cand   = m_pend & m_msk;
      ackv   = w && (a == ICUR) && (m_phase == 2) && (d[7:0] == 8'(m_cur));
      clrv   = '0;
      if (ackv) clrv[m_cur] = 1'b1;
      rise   = r & ~m_prev;
      nphase = m_phase;
      if (m_phase == 0) begin
         if (cand != 0) nphase = 1;
      end else if (m_phase == 1) begin
`ifdef INTR_ROUNDROBIN_EN
         win = pick(cand, m_rr);
`else
         win = pick(cand, 0);
`endif
         if (win < 0) nphase = 0;
         else begin
            m_cur  = win;
            nphase = 2;
         end
      end else if (ackv) begin
         nphase = 0;
         m_rr   = (m_cur + 1) % NDEV;
      end
      m_pend  = (m_pend & ~clrv) | rise;
      if (w && (a == IMASK)) m_msk = d[NDEV-1:0];
      m_prev  = r;
      m_phase = nphase;
   endtask

   task automatic cyc(input logic rst, input logic [NDEV-1:0] r, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
      reset_n = rst; dev_req = r; wren = w; abus = a; dbus = d;
      #1;
      last_rd = dbusout;
      check("dbusout", dbusout, model_rd(w, a));
      @(posedge clk);
      model_step(rst, r, w, a, d);
      #1;
      last_intr = intr;
      last_id   = intr_id;
      check("intr", {31'b0, intr}, {31'b0, (m_phase == 2)});
      if (m_phase == 2) check("intr_id", {24'b0, intr_id}, 32'(m_cur));
   endtask

   int exp_first;

   initial begin
      reset_n = 1'b0; dev_req = 4'hF; wren = 1'b0; abus = 32'h0; dbus = 32'h0;
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      check("rst_intr", {31'b0, intr}, 32'h0);
      cyc(1'b0, 4'hF, 1'b0, ISTAT, 0); check("rst_istat", last_rd, 32'h0);
      cyc(1'b0, 4'hF, 1'b0, IMASK, 0); check("rst_imask", last_rd, 32'h0);
      cyc(1'b0, 4'h0, 1'b0, ICUR, 0);  check("rst_icur", last_rd, 32'h0);

      // Single request and latency
      cyc(1'b1, 4'h0, 1'b1, IMASK, 32'h1);
      cyc(1'b1, 4'h1, 1'b0, OTHER, 0); check("lat_k", {31'b0, last_intr}, 32'h0);
      cyc(1'b1, 4'h1, 1'b0, OTHER, 0); check("lat_k1", {31'b0, last_intr}, 32'h0);
      cyc(1'b1, 4'h1, 1'b0, ISTAT, 0); check("single_istat", last_rd, 32'h1);
      check("lat_k2", {31'b0, last_intr}, 32'h1);
      check("single_id", {24'b0, last_id}, 32'h0);
      cyc(1'b1, 4'h1, 1'b1, ICUR, 32'h0); check("eoi_intr", {31'b0, last_intr}, 32'h0);
      cyc(1'b1, 4'h1, 1'b0, ISTAT, 0); check("eoi_istat", last_rd, 32'h0);

      // Bad ack
      cyc(1'b1, 4'h1, 1'b1, IMASK, 32'h4);
      repeat (3) cyc(1'b1, 4'h4, 1'b0, OTHER, 0);
      check("bad_serve_id", {24'b0, last_id}, 32'h2);
      cyc(1'b1, 4'h4, 1'b1, ICUR, 32'h1); check("bad_ack_intr", {31'b0, last_intr}, 32'h1);
      cyc(1'b1, 4'h4, 1'b0, ICUR, 0);     check("bad_ack_icur", last_rd, 32'h80000002);
      cyc(1'b1, 4'h0, 1'b1, ICUR, 32'h2);

      // Masked request, then enable
      cyc(1'b1, 4'h0, 1'b1, IMASK, 32'h0);
      cyc(1'b1, 4'h8, 1'b0, OTHER, 0);
      cyc(1'b1, 4'h0, 1'b0, OTHER, 0);
      cyc(1'b1, 4'h0, 1'b0, ISTAT, 0); check("masked_istat", last_rd, 32'h8);
      check("masked_intr", {31'b0, last_intr}, 32'h0);
      cyc(1'b1, 4'h0, 1'b1, IMASK, 32'h8);
      repeat (2) cyc(1'b1, 4'h0, 1'b0, OTHER, 0);
      check("unmask_intr", {31'b0, last_intr}, 32'h1);
      check("unmask_id", {24'b0, last_id}, 32'h3);
      cyc(1'b1, 4'h0, 1'b1, ICUR, 32'h3);

      // Contention plus ack/edge collision on id 1
      cyc(1'b1, 4'h0, 1'b1, IMASK, 32'hF);
      repeat (3) cyc(1'b1, 4'h6, 1'b0, OTHER, 0);
      check("cont_first", {24'b0, last_id}, 32'h1);
      cyc(1'b1, 4'h4, 1'b0, OTHER, 0);
      cyc(1'b1, 4'h6, 1'b1, ICUR, 32'h1); check("coll_intr", {31'b0, last_intr}, 32'h0);
      cyc(1'b1, 4'h6, 1'b0, ISTAT, 0);    check("coll_istat", last_rd, 32'h6);
      cyc(1'b1, 4'h6, 1'b0, OTHER, 0);
`ifdef INTR_ROUNDROBIN_EN
      exp_first = 2;
`else
      exp_first = 1;
`endif
      check("cont_next", {24'b0, last_id}, 32'(exp_first));
      cyc(1'b1, 4'h6, 1'b1, ICUR, 32'(exp_first));
      repeat (2) cyc(1'b1, 4'h6, 1'b0, OTHER, 0);
      check("cont_last", {24'b0, last_id}, 32'(3 - exp_first));
      cyc(1'b1, 4'h0, 1'b1, ICUR, 32'(3 - exp_first));

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic            rst, w;
         logic [31:0]     a, d;
         logic [NDEV-1:0] r;
         logic [31:0]     addrs [4];
         addrs[0] = ISTAT; addrs[1] = IMASK; addrs[2] = ICUR; addrs[3] = OTHER;
         rst = ($urandom_range(0, 199) != 0);
         r   = dev_req;
         for (int b = 0; b < NDEV; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
         d   = $urandom;
         a   = addrs[$urandom_range(0, 3)];
         w   = ($urandom_range(0, 3) == 0);
         if (m_phase == 2 && $urandom_range(0, 2) == 0) begin
            w = 1'b1;
            a = ICUR;
            if ($urandom_range(0, 3) != 0) d[7:0] = 8'(m_cur);
         end
         cyc(rst, r, w, a, d);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
